// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_pkg: shared state encoding, trace record layout and index-width helper
package cpu_trace_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} state_t;
  localparam int REC_PC_W = 32;
  localparam int REC_INSTR_W = 32;
  localparam int REC_RA_W = 5;
  localparam int REC_DA_W = 32;
  typedef struct packed {
    logic [REC_PC_W-1:0]    pc;
    logic [REC_INSTR_W-1:0] instr;
    logic [REC_RA_W-1:0]    regw;
    logic [REC_DA_W-1:0]    daddr;
  } trace_rec_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: single-write, single-registered-read record store (read returns pre-write contents)
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int W = 101
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular retired-instruction trace with pc trigger, post window and watchdog freeze
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int RA_W = 5,
  parameter int DA_W = 32,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 4,
  parameter int CNT_W = 17,
  parameter int MAX_CYCLES = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    cap_en,
  input  logic [PC_W-1:0]         pc,
  input  logic [INSTR_W-1:0]      instr,
  input  logic                    reg_wen,
  input  logic [RA_W-1:0]         reg_waddr,
  input  logic [DA_W-1:0]         dm_addr,
  input  logic                    trig_en,
  input  logic [PC_W-1:0]         trig_pc,
  input  logic                    rd_en,
  input  logic [clog2(DEPTH)-1:0] rd_idx,
  output logic                    rd_valid,
  output logic                    rd_err,
  output logic [PC_W-1:0]         rd_pc,
  output logic [INSTR_W-1:0]      rd_instr,
  output logic [RA_W-1:0]         rd_regw,
  output logic [DA_W-1:0]         rd_daddr,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [clog2(DEPTH):0]   entries,
  output logic                    triggered,
  output logic                    done,
  output logic                    timeout
);
  localparam int IW = clog2(DEPTH);
  localparam int RW = PC_W + INSTR_W + RA_W + DA_W;
  state_t state_q;
  logic [IW-1:0] wptr_q, post_q, raddr;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic wrapped_q, trig_q, done_q, tmo_q, valid_q, err_q, errh_q;
  logic cap, hit, wd, oob;
  logic [RW-1:0] rdata;
  assign cap = !arm && cap_en && (state_q == ARMED || state_q == POST);
  assign hit = state_q == ARMED && trig_en && pc == trig_pc;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign wd = cnt_inc == CNT_W'(MAX_CYCLES);
  assign entries = wrapped_q ? (IW+1)'(DEPTH) : {1'b0, wptr_q};
  // Once wrapped, the write pointer sits on the oldest record
  assign raddr = (wrapped_q ? wptr_q : {IW{1'b0}}) + rd_idx;
  assign oob = {1'b0, rd_idx} >= entries;
  assign cycle_cnt = cnt_q;
  assign triggered = trig_q;
  assign done = done_q;
  assign timeout = tmo_q;
  assign rd_valid = valid_q;
  assign rd_err = err_q;
  assign {rd_pc, rd_instr, rd_regw, rd_daddr} = errh_q ? {RW{1'b0}} : rdata;
  trace_ram #(.DEPTH(DEPTH), .AW(IW), .W(RW)) u_ram (
    .clk(clk),
    .reset(reset),
    .we_i(cap),
    .waddr_i(wptr_q),
    .wdata_i({pc, instr, reg_wen ? reg_waddr : {RA_W{1'b0}}, dm_addr}),
    .re_i(rd_en),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q <= '0;
      post_q <= '0;
      cnt_q <= '0;
      wrapped_q <= 1'b0;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
    end else if (arm) begin
      state_q <= ARMED;
      wptr_q <= '0;
      post_q <= '0;
      cnt_q <= '0;
      wrapped_q <= 1'b0;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
    end else if (cap) begin
      wptr_q <= wptr_q + 1'b1;
      cnt_q <= cnt_inc;
      if (&wptr_q) wrapped_q <= 1'b1;
      if (hit) begin
        trig_q <= 1'b1;
        post_q <= IW'(POST_TRIG);
      end else if (state_q == POST) post_q <= post_q - 1'b1;
      if (wd) tmo_q <= 1'b1;
      if (wd || (hit && POST_TRIG == 0) || (state_q == POST && post_q == IW'(1))) begin
        state_q <= FROZEN;
        done_q <= 1'b1;
      end else if (hit) state_q <= POST;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q <= 1'b0;
      errh_q <= 1'b0;
    end else begin
      valid_q <= rd_en;
      err_q <= rd_en && oob;
      if (rd_en) errh_q <= oob;
    end
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: randomized scoreboard bench against a record-history reference model
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;
  localparam int DEPTH = 16;
  localparam int POST_TRIG = 4;
  localparam int MAX_CYCLES = 32;
  localparam int CNT_MAX = (1 << 17) - 1;
  logic clk = 1'b0;
  logic reset, arm, cap_en, reg_wen, trig_en, rd_en;
  logic [31:0] pc, instr, dm_addr, trig_pc;
  logic [4:0] reg_waddr;
  logic [3:0] rd_idx;
  logic rd_valid, rd_err, triggered, done, timeout;
  logic [31:0] rd_pc, rd_instr, rd_daddr;
  logic [4:0] rd_regw;
  logic [16:0] cycle_cnt;
  logic [4:0] entries;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {bit err; trace_rec_t rec;} exp_t;
  exp_t sbq[$];
  trace_rec_t hist[$];
  int m_cnt, m_left;
  bit m_trig, m_done, m_tmo, m_active, m_post;
  logic [101:0] mon_act, mon_exp;

  cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cap_en(cap_en), .pc(pc), .instr(instr),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .dm_addr(dm_addr), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_regw(rd_regw), .rd_daddr(rd_daddr),
    .cycle_cnt(cycle_cnt), .entries(entries), .triggered(triggered), .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid with no read outstanding");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        mon_act = {rd_err, rd_pc, rd_instr, rd_regw, rd_daddr};
        mon_exp = {e.err, e.err ? 101'b0 : e.rec};
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  function automatic void model_clear();
    hist.delete();
    m_cnt = 0; m_left = 0;
    m_trig = 0; m_done = 0; m_tmo = 0; m_post = 0;
  endfunction

  function automatic void freeze();
    m_active = 0;
    m_done = 1;
  endfunction

  function automatic void model_step();
    if (arm) begin
      model_clear();
      m_active = 1;
    end else if (m_active && cap_en) begin
      trace_rec_t r;
      r.pc = pc; r.instr = instr; r.daddr = dm_addr;
      r.regw = reg_wen ? reg_waddr : 5'd0;
      hist.push_back(r);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_post) begin
        m_left--;
        if (m_left == 0) freeze();
      end else if (trig_en && pc == trig_pc) begin
        m_trig = 1; m_post = 1; m_left = POST_TRIG;
        if (m_left == 0) freeze();
      end
      if (m_cnt == MAX_CYCLES) begin
        m_tmo = 1;
        freeze();
      end
    end
  endfunction

  task automatic tick();
    bit ev;
    ev = rd_en;
    if (rd_en) begin
      exp_t e;
      e.err = rd_idx >= hist.size();
      e.rec = '0;
      if (!e.err) e.rec = hist[rd_idx];
      sbq.push_back(e);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("rd_valid", rd_valid, ev);
    if (!ev) chk("rd_err_idle", rd_err, 0);
    chk("entries", entries, hist.size());
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("triggered", triggered, m_trig);
    chk("done", done, m_done);
    chk("timeout", timeout, m_tmo);
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic cap(input logic [31:0] p, input logic wen, input logic [4:0] wa);
    cap_en = 1; pc = p; instr = $urandom; dm_addr = $urandom; reg_wen = wen; reg_waddr = wa;
    tick();
    cap_en = 0;
  endtask

  task automatic rd(input int idx);
    rd_en = 1; rd_idx = idx[3:0];
    tick();
    rd_en = 0;
  endtask

  initial begin
    reset = 1; arm = 0; cap_en = 0; reg_wen = 0; trig_en = 0; rd_en = 0;
    pc = 0; instr = 0; dm_addr = 0; trig_pc = 0; reg_waddr = 0; rd_idx = 0;
    model_clear(); m_active = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_rd_pc", rd_pc, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_entries", entries, 0);
    chk("reset_done", done, 0);
    reset = 0;
    tick();
    // reset mid-capture must clear status without waiting for a clock edge
    do_arm();
    for (int i = 0; i < 5; i++) cap(32'h40 + 4 * i, 1, 5'(i));
    #2 reset = 1;
    #1;
    chk("async_entries", entries, 0);
    chk("async_cycle_cnt", cycle_cnt, 0);
    chk("async_done", done, 0);
    model_clear(); m_active = 0;
    @(negedge clk);
    reset = 0;
    tick();
    do_arm();
    for (int i = 0; i < 10; i++) cap(4 * i, 1, 5'(i));
    chk("nowrap_entries", entries, 10);
    rd(0); rd(9); rd(10);
    do_arm();
    for (int k = 0; k < 20; k++) cap(4 * k, k[0], 5'(k));
    chk("wrap_entries", entries, 16);
    chk("wrap_cycle_cnt", cycle_cnt, 20);
    rd(0);
    chk("wrap_oldest_pc", rd_pc, 16);
    rd(15);
    chk("wrap_newest_pc", rd_pc, 76);
    rd(7);
    trig_en = 1; trig_pc = 32'h20;
    do_arm();
    for (int k = 0; k < 20; k++) begin
      cap(4 * k, 1, 5'd3);
      tick();
    end
    chk("trig_triggered", triggered, 1);
    chk("trig_entries", entries, 13);
    rd(12);
    chk("trig_last_pc", rd_pc, 32'h30);
    rd(13);
    trig_en = 0;
    do_arm();
    cap(32'h100, 0, 5'd7);
    cap(32'h104, 1, 5'd7);
    rd(0);
    chk("regw_gated", rd_regw, 0);
    rd(1);
    chk("regw_written", rd_regw, 7);
    do_arm();
    for (int k = 0; k < 40; k++) cap(32'h200 + 4 * k, 1, 5'(k));
    chk("wd_timeout", timeout, 1);
    chk("wd_cycle_cnt", cycle_cnt, MAX_CYCLES);
    chk("wd_done", done, 1);
    rd(0);
    do_arm();
    chk("rearm_timeout", timeout, 0);
    chk("rearm_entries", entries, 0);
    cap(32'h300, 1, 5'd9);
    rd(0);
    chk("rearm_pc", rd_pc, 32'h300);
    trig_pc = 32'h20;
    for (int c = 0; c < 400; c++) begin
      arm = $urandom_range(0, 30) == 0;
      cap_en = $urandom_range(0, 2) != 0;
      pc = 32'($urandom_range(0, 15) * 4);
      instr = $urandom; dm_addr = $urandom;
      reg_wen = 1'($urandom); reg_waddr = 5'($urandom);
      trig_en = 1'($urandom);
      rd_en = 1'($urandom);
      rd_idx = 4'($urandom);
      tick();
    end
    arm = 0; cap_en = 0; rd_en = 0;
    tick();
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesisable, parametrised on-chip instruction trace recorder for the cpu2 core.
- Replaces ad-hoc per-cycle printing of pc, instruction, regfile write address and data-memory address.
- Captures one record per retired cycle into a circular buffer, with a pc-match trigger, post-trigger window and cycle watchdog, then freezes for registered readout by a bench or debug port.

Parameters:
- PC_W, 32, pc width.
- INSTR_W, 32, instruction width.
- RA_W, 5, regfile address width.
- DA_W, 32, data-memory address width.
- DEPTH, 16, trace entries; power of two, ≥2.
- POST_TRIG, 4, entries captured after the trigger entry; must be < DEPTH.
- CNT_W, 17, cycle counter width.
- MAX_CYCLES, 512, watchdog limit on captured cycles; ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  start or restart capture.
- cap_en  in  1  core retired an instruction this cycle.
- pc  in  PC_W  pc of the retiring instruction.
- instr  in  INSTR_W  retiring instruction.
- reg_wen  in  1  regfile write enable.
- reg_waddr  in  RA_W  regfile write address.
- dm_addr  in  DA_W  data-memory address.
- trig_en  in  1  enable pc-match trigger.
- trig_pc  in  PC_W  trigger pc.
- rd_en  in  1  readout request.
- rd_idx  in  log2(DEPTH)  entry index; 0 = oldest.
- rd_valid  out  1  readout data valid.
- rd_err  out  1  rd_idx beyond the valid entry count.
- rd_pc  out  PC_W  read record pc.
- rd_instr  out  INSTR_W  read record instruction.
- rd_regw  out  RA_W  read record regfile write address.
- rd_daddr  out  DA_W  read record data-memory address.
- cycle_cnt  out  CNT_W  captured cycles since arm.
- entries  out  log2(DEPTH)+1  valid entries held.
- triggered  out  1  trigger seen.
- done  out  1  buffer frozen.
- timeout  out  1  frozen by the watchdog.

Behaviour:
- Reset (async, active-high): state IDLE; wptr=0, wrapped=0; all outputs 0. Storage contents are don't-care but can never be read, since entries=0.
- States: IDLE, ARMED, POST, FROZEN.
  - arm=1 in any state → ARMED next cycle. Clears wptr, wrapped, cycle_cnt, triggered, done and timeout. arm has priority over capture that cycle; nothing is written.
- Capture occurs in ARMED/POST when cap_en=1:
  - Record written at wptr: {pc, instr, reg_wen ? reg_waddr : 0, dm_addr}.
  - wptr increments; on wrap from DEPTH−1 to 0, wrapped is set sticky.
  - cycle_cnt increments and saturates at all-ones.
  - cap_en=0 → no write, no count.
- Trigger (ARMED only): on a capture cycle with trig_en=1 and pc==trig_pc, the entry is captured, triggered=1, post_left=POST_TRIG.
  - post_left=0 → FROZEN.
  - Otherwise → POST. Each further capture decrements post_left; the capture taking it to 0 → FROZEN.
  - pc matches in POST are ignored.
- Watchdog: the capture making cycle_cnt==MAX_CYCLES → FROZEN with timeout=1, regardless of state.
  - If trigger and watchdog fire on the same capture: both flags set and the block goes FROZEN.
- FROZEN: no captures; done=1 until arm or reset.
- entries = wrapped ? DEPTH : wptr.
- Readout is legal in every state and has 1-cycle latency.
  - rd_en at cycle N → rd_valid=1 at N+1. Data is taken from physical index (wrapped ? wptr : 0) + rd_idx, modulo DEPTH.
  - rd_idx ≥ entries → rd_err=1 and data 0.
  - rd_valid/rd_err are single-cycle pulses; data holds until the next read.
  - A read of the entry being written in the same cycle returns the old contents (read-before-write).

Decomposition:
- Package cpu_trace_pkg: state enum; trace record struct {pc, instr, regw, daddr}; index-width function clog2(DEPTH).
- One sub-module, trace_ram: DEPTH×record single-write, single-registered-read memory.
- FSM, pointers, trigger and watchdog stay in the top.

Test Plan:
- Reset mid-capture: 5 captures, then assert reset → entries=0, cycle_cnt=0 and done=0 immediately, without waiting for clk.
- No wrap: arm, 10 captures with pc=0,4,…,36 → entries=10; read idx 0 gives pc 0; idx 9 gives pc 36; idx 10 gives rd_err=1.
- Wrap: DEPTH=16, 20 captures with pc=4k → wrapped; entries=16; idx 0 gives pc 16; idx 15 gives pc 76; cycle_cnt=20.
- Trigger: trig_pc=0x20, POST_TRIG=4, pc stepping by 4 from 0 with cap_en gapped every other cycle → triggered on pc 0x20; frozen after pc 0x30 (entries=13, last record pc 0x30); later captures ignored.
- reg_wen gating: capture with reg_wen=0 and reg_waddr=7 → rd_regw=0; with reg_wen=1 → rd_regw=7.
- Watchdog plus re-arm: MAX_CYCLES=32, no trigger, 40 captures → timeout=1 and done at cycle_cnt=32. Then arm → all flags clear and capture resumes at wptr=0.
